// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and the alignment rule for the multicycle data memory.
package dmem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] F3_SB = 2'b00;
    localparam logic [1:0] F3_SH = 2'b01;
    localparam logic [1:0] F3_SW = 2'b10;

    localparam int READ_REQ_BIT  = 3;
    localparam int WRITE_REQ_BIT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        ACK  = 2'b10
    } state_t;

    // funct3[1:0] encodes the access size identically for loads and stores.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            F3_SB:   return 1'b0;
            F3_SH:   return addr_lo[0];
            default: return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: load extract/extend and store byte-lane merge.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] mem_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [3:0]  byte_en;
    logic [31:0] lane_data;

    always_comb begin
        byte_sel = mem_word[{addr_lo, 3'b000} +: 8];
        half_sel = mem_word[{addr_lo[1], 4'b0000} +: 16];

        case (funct3)
            F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  load_data = {24'd0, byte_sel};
            F3_LHU:  load_data = {16'd0, half_sel};
            F3_LW:   load_data = mem_word;
            default: load_data = mem_word;
        endcase

        // Store data is replicated across lanes so the byte enables alone pick the target.
        case (funct3[1:0])
            F3_SB: begin
                byte_en   = 4'b0001 << addr_lo;
                lane_data = {4{store_data[7:0]}};
            end
            F3_SH: begin
                byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{store_data[15:0]}};
            end
            F3_SW: begin
                byte_en   = 4'b1111;
                lane_data = store_data;
            end
            default: begin
                byte_en   = 4'b1111;
                lane_data = store_data;
            end
        endcase

        merged_word = mem_word;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) merged_word[8*i +: 8] = lane_data[8*i +: 8];
        end
    end

endmodule

// File: rtl/dmem_multicycle.sv
// Multicycle data memory for the MA stage: IDLE/BUSY/ACK handshake via BUSYWAIT,
// configurable load/store latency, misaligned accesses reported without touching the array.
module dmem_multicycle
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int DEPTH_WORDS   = 256,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [3:0]            READ,
    input  logic [2:0]            WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDRESS,
    input  logic [31:0]           WRITEDATA,
    output logic [31:0]           READDATA,
    output logic                  BUSYWAIT,
    output logic                  MISALIGNED
);

    localparam int IDX_W   = $clog2(DEPTH_WORDS);
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] RD_CNT_INIT = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_CNT_INIT = CNT_W'(WRITE_LATENCY - 1);

    logic [31:0]      mem [DEPTH_WORDS];
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             op_load;
    logic [2:0]       f3_q;
    logic [IDX_W+1:0] addr_q;
    logic [31:0]      wdata_q;

    logic             rd_req, wr_req, req, req_mis, mem_we;
    logic [2:0]       req_f3;
    logic [31:0]      mem_word, load_data, merged_word;
    logic             unused_addr;

    // A simultaneous load wins; the store request is simply not latched.
    assign rd_req  = READ[READ_REQ_BIT];
    assign wr_req  = WRITE[WRITE_REQ_BIT];
    assign req     = rd_req | wr_req;
    assign req_f3  = rd_req ? READ[2:0] : {1'b0, WRITE[1:0]};
    assign req_mis = is_misaligned(req_f3[1:0], ADDRESS[1:0]);

    assign BUSYWAIT = RST && ((state == BUSY) || ((state == IDLE) && req));

    assign unused_addr = ^ADDRESS[ADDR_WIDTH-1:IDX_W+2];

    assign mem_word = mem[addr_q[IDX_W+1:2]];
    assign mem_we   = RST && (state == BUSY) && (cnt == '0) && !op_load;

    dmem_lane_align u_lane_align (
        .funct3      (f3_q),
        .addr_lo     (addr_q[1:0]),
        .mem_word    (mem_word),
        .store_data  (wdata_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_ff @(posedge CLK) begin
        if ((state == IDLE) && req) begin
            f3_q    <= req_f3;
            addr_q  <= ADDRESS[IDX_W+1:0];
            wdata_q <= WRITEDATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) mem[addr_q[IDX_W+1:2]] <= merged_word;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            cnt        <= '0;
            op_load    <= 1'b0;
            READDATA   <= '0;
            MISALIGNED <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    MISALIGNED <= 1'b0;
                    if (req) begin
                        op_load <= rd_req;
                        if (req_mis) begin
                            state      <= ACK;
                            MISALIGNED <= 1'b1;
                            if (rd_req) READDATA <= '0;
                        end else begin
                            state <= BUSY;
                            cnt   <= rd_req ? RD_CNT_INIT : WR_CNT_INIT;
                        end
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= ACK;
                        if (op_load) READDATA <= load_data;
                    end
                end
                ACK: begin
                    state      <= IDLE;
                    MISALIGNED <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_multicycle.sv
// Directed bench for dmem_multicycle with a word-array reference model and an idle-cycle monitor.
module tb_dmem_multicycle;

    localparam int RL    = 2;
    localparam int WL    = 2;
    localparam int DEPTH = 256;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  READ;
    logic [2:0]  WRITE;
    logic [31:0] ADDRESS;
    logic [31:0] WRITEDATA;
    logic [31:0] READDATA;
    logic        BUSYWAIT;
    logic        MISALIGNED;

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 0;
    bit in_txn = 0;
    logic [31:0] exp_rdata = 32'h0;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] got;

    dmem_multicycle #(
        .ADDR_WIDTH    (32),
        .DEPTH_WORDS   (DEPTH),
        .READ_LATENCY  (RL),
        .WRITE_LATENCY (WL)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .READ       (READ),
        .WRITE      (WRITE),
        .ADDRESS    (ADDRESS),
        .WRITEDATA  (WRITEDATA),
        .READDATA   (READDATA),
        .BUSYWAIT   (BUSYWAIT),
        .MISALIGNED (MISALIGNED)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int model_size(input logic [1:0] sz);
        if (sz == 2'd0) return 1;
        if (sz == 2'd1) return 2;
        return 4;
    endfunction

    function automatic bit model_mis(input logic [1:0] sz, input logic [1:0] a);
        return (int'(a) % model_size(sz)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] a);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b & 32'h80) != 0 ? (b | 32'hFFFFFF00) : b;
            3'b001:  return (h & 32'h8000) != 0 ? (h | 32'hFFFF0000) : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [1:0] a, input logic [31:0] d);
        logic [31:0] r;
        r = w;
        for (int k = 0; k < model_size(sz); k++) r[8*(int'(a)+k) +: 8] = d[8*k +: 8];
        return r;
    endfunction

    // One access: drive the request, count BUSYWAIT-high cycles, check the ACK cycle, update the model.
    task automatic access(input bit ld, input logic [2:0] rf3, input bit st, input logic [2:0] wf3,
                          input logic [31:0] addr, input logic [31:0] wd, input string tag,
                          output logic [31:0] res);
        logic [2:0] ef3;
        bit mis;
        int exp_n;
        int n;
        int widx;
        ef3   = ld ? rf3 : {1'b0, wf3[1:0]};
        mis   = model_mis(ef3[1:0], addr[1:0]);
        exp_n = mis ? 1 : ((ld ? RL : WL) + 1);
        widx  = int'((addr >> 2) % DEPTH);
        @(negedge CLK);
        in_txn    = 1;
        READ      = {ld, rf3};
        WRITE     = {st, wf3[1:0]};
        ADDRESS   = addr;
        WRITEDATA = wd;
        n = 0;
        #1;
        while (BUSYWAIT === 1'b1 && n < 40) begin
            n++;
            @(negedge CLK);
            ADDRESS   = $urandom;
            WRITEDATA = $urandom;
            #1;
        end
        READ  = 4'b0;
        WRITE = 3'b0;
        if (ld) exp_rdata = mis ? 32'h0 : model_load(model_mem[widx], rf3, addr[1:0]);
        else if (!mis) model_mem[widx] = model_store(model_mem[widx], wf3[1:0], addr[1:0], wd);
        check({tag, "_busy"}, 32'(n), 32'(exp_n));
        check({tag, "_mis"}, {31'b0, MISALIGNED}, {31'b0, mis});
        check({tag, "_rdata"}, READDATA, exp_rdata);
        res = READDATA;
        @(posedge CLK);
        in_txn = 0;
    endtask

    // Idle-cycle monitor: no stall, outputs hold, MISALIGNED back low.
    always @(negedge CLK) begin
        if (mon_en && !in_txn) begin
            check("idle_busywait", {31'b0, BUSYWAIT}, 32'h0);
            check("idle_rdata", READDATA, exp_rdata);
            check("idle_mis", {31'b0, MISALIGNED}, 32'h0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        RST = 1'b0; READ = 4'b1010; WRITE = 3'b0; ADDRESS = 32'h10; WRITEDATA = 32'h0;
        repeat (2) @(negedge CLK);
        #1;
        check("rst_busywait", {31'b0, BUSYWAIT}, 32'h0);
        check("rst_rdata", READDATA, 32'h0);
        check("rst_mis", {31'b0, MISALIGNED}, 32'h0);
        READ = 4'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        mon_en = 1;

        access(0, 3'b000, 1, 3'b010, 32'h10, 32'hDEADBEEF, "sw10", got);
        access(1, 3'b010, 0, 3'b000, 32'h10, 32'h0, "lw10", got);
        check("lit_lw10", got, 32'hDEADBEEF);
        access(1, 3'b000, 0, 3'b000, 32'h13, 32'h0, "lb13", got);
        check("lit_lb13", got, 32'hFFFFFFDE);
        access(1, 3'b100, 0, 3'b000, 32'h13, 32'h0, "lbu13", got);
        check("lit_lbu13", got, 32'h000000DE);
        access(1, 3'b001, 0, 3'b000, 32'h10, 32'h0, "lh10", got);
        check("lit_lh10", got, 32'hFFFFBEEF);
        access(1, 3'b101, 0, 3'b000, 32'h12, 32'h0, "lhu12", got);
        check("lit_lhu12", got, 32'h0000DEAD);

        access(0, 3'b000, 1, 3'b000, 32'h11, 32'h00000055, "sb11", got);
        access(1, 3'b010, 0, 3'b000, 32'h10, 32'h0, "lw_after_sb", got);
        check("lit_lw_after_sb", got, 32'hDEAD55EF);
        access(0, 3'b000, 1, 3'b001, 32'h12, 32'h00001234, "sh12", got);
        access(1, 3'b010, 0, 3'b000, 32'h10, 32'h0, "lw_after_sh", got);
        check("lit_lw_after_sh", got, 32'h123455EF);

        access(1, 3'b010, 0, 3'b000, 32'h11, 32'h0, "lw_mis", got);
        check("lit_lw_mis", got, 32'h0);
        access(0, 3'b000, 1, 3'b010, 32'h12, 32'hCAFEF00D, "sw_mis", got);
        access(1, 3'b010, 0, 3'b000, 32'h10, 32'h0, "lw_after_swmis", got);
        check("lit_lw_after_swmis", got, 32'h123455EF);

        access(0, 3'b000, 1, 3'b010, 32'h20, 32'h0, "sw20_zero", got);
        @(negedge CLK);
        in_txn = 1;
        WRITE = 3'b110; ADDRESS = 32'h20; WRITEDATA = 32'hAAAAAAAA;
        @(posedge CLK);
        @(negedge CLK);
        WRITE = 3'b0;
        RST   = 1'b0;
        #1;
        exp_rdata = 32'h0;
        check("midrst_busywait", {31'b0, BUSYWAIT}, 32'h0);
        check("midrst_rdata", READDATA, 32'h0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("midrst_release_busywait", {31'b0, BUSYWAIT}, 32'h0);
        @(posedge CLK);
        in_txn = 0;
        access(1, 3'b010, 0, 3'b000, 32'h20, 32'h0, "lw20_after_rst", got);
        check("lit_lw20_after_rst", got, 32'h0);

        access(0, 3'b000, 1, 3'b010, 32'h400, 32'h5A5A5A5A, "sw_wrap", got);
        access(1, 3'b010, 0, 3'b000, 32'h0, 32'h0, "lw_wrap", got);
        check("lit_lw_wrap", got, 32'h5A5A5A5A);

        access(1, 3'b010, 1, 3'b010, 32'h10, 32'hFFFFFFFF, "both", got);
        check("lit_both", got, 32'h123455EF);
        access(1, 3'b010, 0, 3'b000, 32'h10, 32'h0, "lw_after_both", got);
        check("lit_lw_after_both", got, 32'h123455EF);

        repeat (3) @(negedge CLK);
        mon_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_multicycle.md
Name: dmem_multicycle

Overview:
Parametrised successor data memory for the MA stage of the RV32IM pipeline. Serves byte, half and word loads and stores, with sign and zero extension, after a configurable number of wait cycles. Raises BUSYWAIT so the pipeline stalls until the access completes. Detects misaligned accesses and reports them without touching the array.

Parameters:
ADDR_WIDTH, 32, width of ADDRESS
DEPTH_WORDS, 256, number of 32-bit words; power of two
READ_LATENCY, 2, wait cycles for a load; must be >= 1
WRITE_LATENCY, 2, wait cycles for a store; must be >= 1

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous, active-low reset
READ  input  4  [3]=load request; [2:0]=funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
WRITE  input  3  [2]=store request; [1:0]=funct3[1:0] (00 SB, 01 SH, 10 SW)
ADDRESS  input  ADDR_WIDTH  byte address
WRITEDATA  input  32  store data, right-aligned
READDATA  output  32  extended load result
BUSYWAIT  output  1  high = stall the pipeline
MISALIGNED  output  1  high in the ACK cycle of a misaligned access

Behaviour:
- States: IDLE, BUSY, ACK.
- Reset (RST=0, asynchronous):
  - state=IDLE, counter=0, READDATA=0, MISALIGNED=0.
  - BUSYWAIT is forced 0 while RST=0.
  - Array contents are not cleared.
- IDLE, with a request (READ[3] or WRITE[2]):
  - BUSYWAIT=1 combinationally in the same cycle.
  - Latch op, funct3, ADDRESS and WRITEDATA at the edge.
- IDLE, aligned request: cnt <= LAT-1, go to BUSY. LAT is READ_LATENCY or WRITE_LATENCY per the latched op.
- IDLE, misaligned request: go directly to ACK, with no array access.
  - Misaligned means: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
- IDLE, READ[3] and WRITE[2] both high: the load is served and the store is dropped.
- BUSY:
  - BUSYWAIT=1.
  - cnt!=0: cnt decrements.
  - cnt==0: perform the access at the edge, then go to ACK.
  - Request inputs are ignored while in BUSY (the latched copy is used).
- ACK:
  - BUSYWAIT=0 for exactly one cycle; READDATA is registered and valid.
  - MISALIGNED=1 only for a misaligned op.
  - Next edge: go to IDLE.
  - A request still present in the following IDLE cycle starts a new access.
- Timing: an aligned access holds BUSYWAIT high for LAT+1 cycles; a misaligned access holds it high for 1 cycle.
- Load extension:
  - LB/LH sign-extend bit 7/15 of the selected lane; LBU/LHU zero-extend.
  - Lane = addr[1:0] for bytes, addr[1] for halves.
  - LW returns the whole word.
- Store merge:
  - SB writes byte lane addr[1:0] with WRITEDATA[7:0].
  - SH writes half lane addr[1] with WRITEDATA[15:0].
  - Other bytes of the word are unchanged.
- Misaligned results: READDATA=0 for a misaligned load; a misaligned store leaves memory untouched.
- After a store ACK, READDATA holds its previous value.
- Word index = ADDRESS[log2(DEPTH_WORDS)+1:2]; upper bits are ignored, so addresses wrap around.
- Reset mid-access: the access is aborted, no array write occurs, and the FSM returns to IDLE.
- No request in IDLE: BUSYWAIT=0, and READDATA and MISALIGNED hold (MISALIGNED returns to 0 after ACK).

Decomposition:
- Package dmem_pkg:
  - funct3 encodings (LB..LHU, SB..SW);
  - state enum (IDLE/BUSY/ACK);
  - request-bit positions;
  - the misalignment function.
- One sub-module, dmem_lane_align (combinational):
  - load extract/extend;
  - store byte-enable and lane merge.
- FSM, counter and array stay in dmem_multicycle.

Test Plan:
- Reset then SW 0xDEADBEEF @0x10 (WRITE=3'b110) -> BUSYWAIT high 3 cycles (LAT=2), then 1 ACK cycle low; a later LW @0x10 (READ=4'b1010) returns 0xDEADBEEF in ACK.
- After the above, LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x10 -> 0xFFFFBEEF; LHU @0x12 -> 0x0000DEAD.
- SB 0x55 @0x11, then LW @0x10 -> 0xDEAD55EF; SH 0x1234 @0x12, then LW @0x10 -> 0x123455EF.
- LW @0x11 -> BUSYWAIT high 1 cycle, ACK with MISALIGNED=1, READDATA=0; SW @0x12 -> MISALIGNED=1, and LW @0x10 is unchanged.
- Assert RST=0 during cycle 1 of BUSY for SW 0xAAAAAAAA @0x20 (word previously 0x0) -> BUSYWAIT drops immediately, state is IDLE after release, LW @0x20 returns 0x0.
- With DEPTH_WORDS=256: SW 0x5A5A5A5A @0x400 (wraps to word 0), then LW @0x0 -> 0x5A5A5A5A; READ and WRITE asserted together -> load served, memory unchanged.
